// File: rtl/uart8051_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart8051_pkg
// Brief   : Shared mode encodings, default oversample ratio and width helper
//           for the 8051-compatible UART.
// Rev     : 1.0  initial release
// ============================================================================
package uart8051_pkg;

    localparam logic [1:0] MODE_SHIFT  = 2'd0;
    localparam logic [1:0] MODE_8B_VAR = 2'd1;
    localparam logic [1:0] MODE_9B_FIX = 2'd2;
    localparam logic [1:0] MODE_9B_VAR = 2'd3;

    localparam int OVS_DEFAULT = 16;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart8051_reload_timer.sv
`default_nettype none
// ============================================================================
// Module : uart8051_reload_timer
// Brief  : Prescaler plus Timer-1 style auto-reload counter; ovf pulses in the
//          cycle the counter rolls over from all-ones.
// Rev    : 1.0  initial release
// ============================================================================
module uart8051_reload_timer
    import uart8051_pkg::*;
#(
    parameter int PRESC    = 12,
    parameter int RELOAD_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                run,
    input  logic [RELOAD_W-1:0] reload,
    output logic                ovf
);

    localparam int                 c_pre_w    = clog2(PRESC);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESC - 1);

    logic [c_pre_w-1:0]  r_pre;
    logic [RELOAD_W-1:0] r_timer;
    logic                w_pre_wrap;

    assign w_pre_wrap = (r_pre == c_pre_last);
    assign ovf        = run & ~start & w_pre_wrap & (&r_timer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_timer <= '0;
        end else if (start) begin
            r_pre   <= '0;
            r_timer <= reload;
        end else if (!run) begin
            r_pre   <= '0;
            r_timer <= '0;
        end else begin
            r_pre <= w_pre_wrap ? '0 : r_pre + c_pre_w'(1);
            // reload is only looked at here and on start
            if (w_pre_wrap) r_timer <= (&r_timer) ? reload : r_timer + RELOAD_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart8051_baud_engine.sv
`default_nettype none
// ============================================================================
// Module : uart8051_baud_engine
// Brief  : 8051 UART baud source: oversample tick, TX bit tick and
//          restartable RX sample/bit ticks for all four serial modes.
// Rev    : 1.0  initial release
// ============================================================================
module uart8051_baud_engine
    import uart8051_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int PRESC    = 12,
    parameter int RELOAD_W = 8,
    parameter int OVS      = OVS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                smod,
    input  logic [RELOAD_W-1:0] reload,
    input  logic                rx_restart,
    output logic                os_tick,
    output logic                tx_tick,
    output logic                rx_sample,
    output logic                rx_bit_tick
);

    localparam int                 c_cnt_w    = clog2(OVS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(OVS - 1);
    localparam logic [c_cnt_w-1:0] c_smp_lo   = c_cnt_w'(OVS / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_smp_hi   = c_cnt_w'(OVS / 2 + 1);

    generate
        if (PRESC < 1 || PRESC > 255 || OVS < 4 || (OVS & (OVS - 1)) != 0 || CLK_FREQ < 1)
        begin : g_param_check
            $error("uart8051_baud_engine: illegal parameter set");
        end
    endgenerate

    logic               r_en_d;
    logic [1:0]         r_mode_d;
    logic               r_smod_d;
    logic               r_half;
    logic [7:0]         r_div_cnt;
    logic [c_cnt_w-1:0] r_tx_cnt;
    logic [c_cnt_w-1:0] r_rx_cnt;

    logic       w_start;
    logic       w_timer_mode;
    logic       w_shift_mode;
    logic       w_run;
    logic       w_ovf;
    logic [7:0] w_div_lim;
    logic       w_div_wrap;
    logic       w_os;
    logic       w_rx_clr;
    logic       w_rx_os;
    logic       w_rx_mid;

    uart8051_reload_timer #(
        .PRESC    (PRESC),
        .RELOAD_W (RELOAD_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .run    (w_run),
        .reload (reload),
        .ovf    (w_ovf)
    );

    always_comb begin
        w_start      = en & (~r_en_d | (mode != r_mode_d) | (smod != r_smod_d));
        w_timer_mode = (mode == MODE_8B_VAR) | (mode == MODE_9B_VAR);
        w_shift_mode = (mode == MODE_SHIFT);
        w_run        = en & w_timer_mode;
        // modes 0/2 use a plain divider; mode 2 is fosc/(OVS*4) or fosc/(OVS*2)
        w_div_lim    = (mode == MODE_9B_FIX) ? (smod ? 8'd2 : 8'd4) : 8'(PRESC);
        w_div_wrap   = (r_div_cnt == w_div_lim - 8'd1);
        w_os         = en & ~w_start &
                       (w_timer_mode ? (w_ovf & (smod | r_half)) : w_div_wrap);
        w_rx_clr     = en & rx_restart;
        w_rx_os      = w_os & ~w_rx_clr;
        w_rx_mid     = (r_rx_cnt >= c_smp_lo) & (r_rx_cnt <= c_smp_hi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_d      <= 1'b0;
            r_mode_d    <= 2'd0;
            r_smod_d    <= 1'b0;
            r_half      <= 1'b0;
            r_div_cnt   <= 8'd0;
            r_tx_cnt    <= '0;
            r_rx_cnt    <= '0;
            os_tick     <= 1'b0;
            tx_tick     <= 1'b0;
            rx_sample   <= 1'b0;
            rx_bit_tick <= 1'b0;
        end else begin
            r_en_d      <= en;
            r_mode_d    <= mode;
            r_smod_d    <= smod;
            os_tick     <= w_os;
            tx_tick     <= w_os & (w_shift_mode | (r_tx_cnt == c_cnt_last));
            rx_sample   <= w_rx_os & (w_shift_mode | w_rx_mid);
            rx_bit_tick <= w_rx_os & (w_shift_mode | (r_rx_cnt == c_cnt_last));
            if (!en || w_start) begin
                r_half    <= 1'b0;
                r_div_cnt <= 8'd0;
                r_tx_cnt  <= '0;
                r_rx_cnt  <= '0;
            end else begin
                r_div_cnt <= (w_timer_mode || w_div_wrap) ? 8'd0 : r_div_cnt + 8'd1;
                if (w_ovf) r_half <= ~r_half;
                if (w_os) r_tx_cnt <= r_tx_cnt + c_cnt_w'(1);
                if (w_rx_clr) r_rx_cnt <= '0;
                else if (w_os) r_rx_cnt <= r_rx_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire
